computie_bus_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer for the Computie multiplexed bus. Sits between internal requesters (e.g. CPU-side port and DMA port) and `computie_bus_ctrl`: grants one requester at a time round-robin, drives the address strobe and read/write strobes, waits for bus acknowledge, returns read data and completion/error status.

---
 rtl/computie_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_computie_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/computie_bus_arbiter.sv
// Round-robin two-requester arbiter and transaction sequencer for the Computie multiplexed bus.
// Define COMPUTIE_BUS_ARB_TIMEOUT_EN to end a stalled WAIT with a bus error after TIMEOUT cycles.
module computie_bus_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req1_valid,
    input  logic                req0_write,
    input  logic                req1_write,
    input  logic [BITWIDTH-1:0] req0_addr,
    input  logic [BITWIDTH-1:0] req1_addr,
    input  logic [BITWIDTH-1:0] req0_wdata,
    input  logic [BITWIDTH-1:0] req1_wdata,
    output logic                req0_done,
    output logic                req1_done,
    output logic                req0_error,
    output logic                req1_error,
    output logic [BITWIDTH-1:0] rdata,
    output logic [BITWIDTH-1:0] addr_out,
    output logic [BITWIDTH-1:0] data_out,
    input  logic [BITWIDTH-1:0] data_in,
    output logic                addr_strobe,
    output logic                read_write,
    input  logic                dtack_n,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // A zero timeout would make the WAIT counter meaningless.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("computie_bus_arbiter: TIMEOUT must be at least 1");
    end

    logic [1:0]          state_q, state_d;
    logic                prio_q, prio_d;     // index of the requester favoured on a tie
    logic                owner_q, owner_d;
    logic                write_q, write_d;
    logic [BITWIDTH-1:0] addr_q, addr_d;
    logic [BITWIDTH-1:0] wdata_q, wdata_d;
    logic [BITWIDTH-1:0] rdata_q, rdata_d;
    logic                strobe_q, strobe_d;
    logic                rw_q, rw_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                busy_q, busy_d;
    logic                grant_s;
    logic                finish_s;

`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic             expire_s;
`endif

    // Next-state and next-output computation for the bus sequencer.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        strobe_d = strobe_q;
        rw_d     = rw_q;
        grant_s  = 1'b0;
        finish_s = 1'b0;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
        tmo_d    = tmo_q;
        expire_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_s  = (req0_valid && req1_valid) ? prio_q : ~req0_valid;
                    owner_d  = grant_s;
                    prio_d   = ~grant_s;
                    write_d  = grant_s ? req1_write : req0_write;
                    addr_d   = grant_s ? req1_addr  : req0_addr;
                    wdata_d  = grant_s ? req1_wdata : req0_wdata;
                    strobe_d = 1'b0;
                    rw_d     = ~write_d;
                    state_d  = ST_ADDR;
                end else begin
                    strobe_d = 1'b1;
                    rw_d     = 1'b1;
                end
            end
            ST_ADDR: begin
                state_d = ST_WAIT;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                // Acknowledge is checked first so it wins over an expiry in the same cycle.
                if (!dtack_n) begin
                    finish_s = 1'b1;
                    if (!write_q) begin
                        rdata_d = data_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    finish_s = 1'b1;
                    expire_s = 1'b1;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
`else
                end else begin
                    finish_s = 1'b0;
`endif
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                strobe_d = 1'b1;
                rw_d     = 1'b1;
            end
        endcase

        if (finish_s) begin
            state_d  = ST_RECOVER;
            strobe_d = 1'b1;
            rw_d     = 1'b1;
        end else begin
            state_d  = state_d;
        end

        done0_d = finish_s & ~owner_q;
        done1_d = finish_s &  owner_q;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
        err0_d  = expire_s & ~owner_q;
        err1_d  = expire_s &  owner_q;
`endif
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any transaction without a completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            strobe_q <= 1'b1;
            rw_q     <= 1'b1;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
            tmo_q    <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
            rw_q     <= rw_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
`endif
        end
    end

    assign addr_out    = addr_q;
    assign data_out    = wdata_q;
    assign rdata       = rdata_q;
    assign addr_strobe = strobe_q;
    assign read_write  = rw_q;
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign busy        = busy_q;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
    assign req0_error  = err0_q;
    assign req1_error  = err1_q;
`else
    assign req0_error  = 1'b0;
    assign req1_error  = 1'b0;
`endif

endmodule

// File: tb/tb_computie_bus_arbiter.sv
// Self-checking bench for computie_bus_arbiter: transaction-level model plus per-cycle compare.
module tb_computie_bus_arbiter;

    localparam int TO = 4;
`ifdef COMPUTIE_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_write, req1_write;
    logic [7:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic       req0_done, req1_done, req0_error, req1_error;
    logic [7:0] rdata, addr_out, data_out, data_in;
    logic       addr_strobe, read_write, dtack_n, busy;

    always #5 clk = ~clk;

    computie_bus_arbiter #(.BITWIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_write(req0_write), .req1_write(req1_write),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_done(req0_done), .req1_done(req1_done),
        .req0_error(req0_error), .req1_error(req1_error),
        .rdata(rdata), .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
        .addr_strobe(addr_strobe), .read_write(read_write), .dtack_n(dtack_n), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int last_grant = -1;

    logic       e_as, e_rw, e_busy, e_d0, e_d1, e_e0, e_e1;
    logic [7:0] e_addr, e_data, e_rdata;

    int n_d0 = 0, n_d1 = 0, n_e0 = 0, n_e1 = 0;
    int done_cyc = 0;
    int done_order[$];
    int sfall[$];
    logic prev_as = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("addr_strobe", 32'(addr_strobe), 32'(e_as));
            chk("read_write",  32'(read_write),  32'(e_rw));
            chk("busy",        32'(busy),        32'(e_busy));
            chk("req0_done",   32'(req0_done),   32'(e_d0));
            chk("req1_done",   32'(req1_done),   32'(e_d1));
            chk("req0_error",  32'(req0_error),  32'(e_e0));
            chk("req1_error",  32'(req1_error),  32'(e_e1));
            chk("addr_out",    32'(addr_out),    32'(e_addr));
            chk("data_out",    32'(data_out),    32'(e_data));
            chk("rdata",       32'(rdata),       32'(e_rdata));
        end
    end

    // Event recorders used by the literal pins.
    always @(negedge clk) begin
        if (req0_done === 1'b1) begin n_d0++; done_cyc = cyc; done_order.push_back(0); end
        if (req1_done === 1'b1) begin n_d1++; done_cyc = cyc; done_order.push_back(1); end
        if (req0_error === 1'b1) n_e0++;
        if (req1_error === 1'b1) n_e1++;
        if (prev_as === 1'b1 && addr_strobe === 1'b0) sfall.push_back(cyc);
        prev_as = addr_strobe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_as = 1'b1; e_rw = 1'b1; e_busy = 1'b0;
        e_d0 = 1'b0; e_d1 = 1'b0; e_e0 = 1'b0; e_e1 = 1'b0;
    endtask

    // Runs one transaction from the current IDLE cycle; wait_n = WAIT cycles before dtack_n falls.
    task automatic txn(input int wait_n, input logic [7:0] din, output int winner);
        logic       wr;
        logic [7:0] a, d;
        bit         expire;
        int         nwait;
        if (req0_valid && req1_valid) winner = (last_grant == 0) ? 1 : 0;
        else winner = req0_valid ? 0 : 1;
        last_grant = winner;
        wr = (winner == 1) ? req1_write : req0_write;
        a  = (winner == 1) ? req1_addr  : req0_addr;
        d  = (winner == 1) ? req1_wdata : req0_wdata;
        expire = TO_EN && (wait_n >= TO);
        nwait  = expire ? TO : wait_n + 1;
        dtack_n = 1'b0;
        data_in = ~din;
        step();
        e_as = 1'b0; e_rw = ~wr; e_addr = a; e_data = d; e_busy = 1'b1;
        dtack_n = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            step();
            dtack_n = (!expire && i == wait_n) ? 1'b0 : 1'b1;
            data_in = (!expire && i == wait_n) ? din : ~din;
        end
        step();
        e_as = 1'b1; e_rw = 1'b1; e_busy = 1'b1;
        e_d0 = (winner == 0); e_d1 = (winner == 1);
        e_e0 = expire && (winner == 0); e_e1 = expire && (winner == 1);
        if (!wr && !expire) e_rdata = din;
        if (winner == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        dtack_n = 1'b0;
        data_in = ~din;
        step();
        set_idle_exp();
    endtask

    int w;
    int t0;
    int d0_before;
    int exp_ord[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_write = 1'b0; req1_write = 1'b0;
        req0_addr = 8'h00; req1_addr = 8'h00; req0_wdata = 8'h00; req1_wdata = 8'h00;
        data_in = 8'h00; dtack_n = 1'b1;
        step();
        set_idle_exp();
        e_addr = 8'h00; e_data = 8'h00; e_rdata = 8'h00;
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Write from req0 with immediate acknowledge.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h12; req0_wdata = 8'h55;
        t0 = cyc;
        sfall.delete();
        txn(0, 8'h00, w);
        chk("t1_done_latency", 32'(done_cyc - t0), 32'd3);
        chk("t1_strobe_latency", 32'(sfall[0] - t0), 32'd1);
        chk("t1_done_count", 32'(n_d0), 32'd1);
        chk("t1_addr_hold", 32'(addr_out), 32'h12);
        chk("t1_data_hold", 32'(data_out), 32'h55);

        // Read from req1, acknowledge on the fourth WAIT cycle.
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h34; req1_wdata = 8'h66;
        txn(3, 8'hAA, w);
        chk("t2_rdata", 32'(rdata), 32'hAA);
        chk("t2_req0_done_count", 32'(n_d0), 32'd1);
        chk("t2_req1_done_count", 32'(n_d1), 32'd1);

        // Stalled read: times out when enabled, otherwise waits 1000 cycles for acknowledge.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h4E; req0_wdata = 8'h11;
        txn(1000, 8'h3C, w);
        chk("t3_rdata", 32'(rdata), TO_EN ? 32'hAA : 32'h3C);
        chk("t3_error_count", 32'(n_e0), TO_EN ? 32'd1 : 32'd0);
        chk("t3_done_count", 32'(n_d0), 32'd2);

        // Reset during WAIT.
        d0_before = n_d0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h56; req0_wdata = 8'h77;
        dtack_n = 1'b1;
        step();
        e_as = 1'b0; e_rw = 1'b1; e_addr = 8'h56; e_data = 8'h77; e_busy = 1'b1;
        last_grant = 0;
        step();
        step();
        reset = 1'b1;
        step();
        set_idle_exp();
        e_addr = 8'h00; e_data = 8'h00; e_rdata = 8'h00;
        last_grant = -1;
        reset = 1'b0; req0_valid = 1'b0; dtack_n = 1'b0;
        chk("rst_strobe", 32'(addr_strobe), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        chk("rst_no_done", 32'(n_d0), 32'(d0_before));

        // Both requesting after reset, then both held continuously.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h9A; req0_wdata = 8'h21;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'hBC; req1_wdata = 8'h43;
        sfall.delete();
        done_order.delete();
        t0 = cyc;
        txn(0, 8'h5A, w);
        txn(1, 8'hC3, w);
        chk("rr_first_strobe", 32'(sfall[0] - t0), 32'd1);
        chk("rr_back_to_back", 32'(sfall[1] - sfall[0]), 32'd4);
        chk("rr_rdata", 32'(rdata), 32'hC3);
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_addr = 8'(8'h60 + i); req1_addr = 8'(8'h70 + i);
            txn(i, 8'(8'h80 + i), w);
        end
        chk("rr_order_len", 32'(done_order.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < done_order.size()) chk("rr_order", 32'(done_order[j]), 32'(exp_ord[j]));
            else chk("rr_order_missing", 32'd0, 32'd1);
        end
        chk("rr_last_rdata", 32'(rdata), 32'h83);

        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
